// File: rtl/uart_alu_top.sv
// UART-controlled 8-bit ALU: serial command/operand bytes load A, B and an opcode,
// and a SEND command returns the combinational ALU result over the serial line.

module baudrate_generator #(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD_RATE   = 9600,
  parameter int COUNT_TICKS = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int DIV = CLK_FREQ / (BAUD_RATE * COUNT_TICKS);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_comb cnt_d = tick ? '0 : cnt_q + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

module uart_rx #(
  parameter int N           = 8,
  parameter int COUNT_TICKS = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx,
  input  logic         tick,
  output logic         rx_done,
  output logic [N-1:0] rx_data
);
  localparam int SW = $clog2(COUNT_TICKS);
  localparam int NW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e     state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [NW-1:0] n_q, n_d;
  logic [N-1:0]  b_q, b_d;
  logic [1:0]    sync_q;
  logic          rx_s;

  // rx is an asynchronous board pin; two flops keep metastability out of the FSM.
  assign rx_s    = sync_q[1];
  assign rx_data = b_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    rx_done = 1'b0;
    case (state_q)
      RX_IDLE: if (!rx_s) begin
        state_d = RX_START;
        s_d     = '0;
      end
      RX_START: if (tick) begin
        if (s_q == SW'(COUNT_TICKS / 2 - 1)) begin
          s_d     = '0;
          n_d     = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else s_d = s_q + 1'b1;
      end
      RX_DATA: if (tick) begin
        if (s_q == SW'(COUNT_TICKS - 1)) begin
          s_d = '0;
          b_d = {rx_s, b_q[N-1:1]};
          if (n_q == NW'(N - 1)) state_d = RX_STOP;
          else                   n_d     = n_q + 1'b1;
        end else s_d = s_q + 1'b1;
      end
      RX_STOP: if (tick) begin
        if (s_q == SW'(COUNT_TICKS - 1)) begin
          rx_done = rx_s;
          state_d = RX_IDLE;
        end else s_d = s_q + 1'b1;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RX_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      sync_q  <= 2'b11;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      sync_q  <= {sync_q[0], rx};
    end
  end
endmodule

module uart_tx #(
  parameter int N           = 8,
  parameter int COUNT_TICKS = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         tx_start,
  input  logic [N-1:0] tx_data,
  output logic         tx_done,
  output logic         tx
);
  localparam int SW = $clog2(COUNT_TICKS);
  localparam int NW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {TX_IDLE, TX_ARM, TX_START, TX_DATA, TX_STOP} tx_state_e;

  tx_state_e     state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [NW-1:0] n_q, n_d;
  logic [N-1:0]  b_q, b_d;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    tx_done = 1'b0;
    case (state_q)
      TX_IDLE: if (tx_start) begin
        b_d     = tx_data;
        state_d = TX_ARM;
      end
      // Hold idle until the next tick so the start bit is a full bit time long.
      TX_ARM: if (tick) begin
        s_d     = '0;
        state_d = TX_START;
      end
      TX_START: if (tick) begin
        if (s_q == SW'(COUNT_TICKS - 1)) begin
          s_d     = '0;
          n_d     = '0;
          state_d = TX_DATA;
        end else s_d = s_q + 1'b1;
      end
      TX_DATA: if (tick) begin
        if (s_q == SW'(COUNT_TICKS - 1)) begin
          s_d = '0;
          b_d = b_q >> 1;
          if (n_q == NW'(N - 1)) state_d = TX_STOP;
          else                   n_d     = n_q + 1'b1;
        end else s_d = s_q + 1'b1;
      end
      TX_STOP: if (tick) begin
        if (s_q == SW'(COUNT_TICKS - 1)) begin
          tx_done = 1'b1;
          state_d = TX_IDLE;
        end else s_d = s_q + 1'b1;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    if (state_q == TX_START)     tx = 1'b0;
    else if (state_q == TX_DATA) tx = b_q[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= TX_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
    end
  end
endmodule

module alu #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] op,
  output logic [N-1:0] y
);
  always_comb begin
    y = '0;
    case (op)
      N'(8'h20): y = a + b;
      N'(8'h22): y = a - b;
      N'(8'h24): y = a & b;
      N'(8'h25): y = a | b;
      N'(8'h26): y = a ^ b;
      N'(8'h27): y = ~(a | b);
      N'(8'h03): y = $signed(a) >>> b;
      N'(8'h02): y = a >> b;
      default:   y = '0;
    endcase
  end
endmodule

module uart_alu_top #(
  parameter int N           = 8,
  parameter int COUNT_TICKS = 16,
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD_RATE   = 9600
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx,
  output logic         tx,
  output logic [N-1:0] data_out,
  output logic [4:0]   state_output
);
  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_LOAD_A  = 5'b00010,
    S_LOAD_B  = 5'b00100,
    S_LOAD_OP = 5'b01000,
    S_SEND    = 5'b10000
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, op_q, op_d;
  logic         tx_start_q, tx_start_d;
  logic         tick, rx_done, tx_done;
  logic [N-1:0] rx_data;

  baudrate_generator #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .COUNT_TICKS(COUNT_TICKS))
    u_baud (.clk(clk), .reset(reset), .tick(tick));

  uart_rx #(.N(N), .COUNT_TICKS(COUNT_TICKS))
    u_rx (.clk(clk), .reset(reset), .rx(rx), .tick(tick), .rx_done(rx_done), .rx_data(rx_data));

  uart_tx #(.N(N), .COUNT_TICKS(COUNT_TICKS))
    u_tx (.clk(clk), .reset(reset), .tick(tick), .tx_start(tx_start_q), .tx_data(data_out),
          .tx_done(tx_done), .tx(tx));

  alu #(.N(N)) u_alu (.a(a_q), .b(b_q), .op(op_q), .y(data_out));

  assign state_output = state_q;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    tx_start_d = 1'b0;
    case (state_q)
      S_IDLE: if (rx_done) begin
        case (rx_data)
          N'(8'h01): state_d = S_LOAD_A;
          N'(8'h02): state_d = S_LOAD_B;
          N'(8'h03): state_d = S_LOAD_OP;
          N'(8'h04): begin
            state_d    = S_SEND;
            tx_start_d = 1'b1;
          end
          default: ;
        endcase
      end
      S_LOAD_A:  if (rx_done) begin a_d  = rx_data; state_d = S_IDLE; end
      S_LOAD_B:  if (rx_done) begin b_d  = rx_data; state_d = S_IDLE; end
      S_LOAD_OP: if (rx_done) begin op_d = rx_data; state_d = S_IDLE; end
      S_SEND:    if (tx_done) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= N'(8'h20);
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tx_start_q <= tx_start_d;
    end
  end
endmodule

// File: tb/tb_uart_alu_top.sv
// Self-checking bench for uart_alu_top: serial byte driver, tx frame monitor and an
// arithmetic ALU reference model; the baud divisor is shrunk to 4 to keep runs short.

module tb_uart_alu_top;
  localparam int N        = 8;
  localparam int CT       = 16;
  localparam int BAUD     = 9600;
  localparam int DIV      = 4;
  localparam int CLK_FREQ = DIV * BAUD * CT;
  localparam int BIT      = DIV * CT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       tx;
  logic [7:0] data_out;
  logic [4:0] state_output;

  int tests = 0;
  int failed = 0;

  logic [7:0] a_m = 8'h00, b_m = 8'h00, op_m = 8'h20;
  logic [9:0] frames[$];
  logic [9:0] mon_f;

  uart_alu_top #(.N(N), .COUNT_TICKS(CT), .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
    .clk(clk), .reset(reset), .rx(rx), .tx(tx), .data_out(data_out), .state_output(state_output)
  );

  always #5 clk = ~clk;

  // Captures each serial frame on tx as {stop, data[7:0], start}, sampled at mid-bit.
  always begin
    @(negedge tx);
    repeat (BIT / 2) @(negedge clk);
    mon_f[0] = tx;
    for (int i = 1; i < 10; i++) begin
      repeat (BIT) @(negedge clk);
      mon_f[i] = tx;
    end
    frames.push_back(mon_f);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] alu_ref(input logic [7:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    int ai, bi, sv, p, r;
    ai = a;
    bi = b;
    case (op)
      8'h20: r = ai + bi;
      8'h22: r = ai - bi + 256;
      8'h24: r = a & b;
      8'h25: r = a | b;
      8'h26: r = a ^ b;
      8'h27: r = 255 - (a | b);
      8'h02: r = (bi >= 8) ? 0 : ai / (1 << bi);
      8'h03: begin
        sv = (ai >= 128) ? ai - 256 : ai;
        if (bi >= 8) r = (sv < 0) ? -1 : 0;
        else begin
          p = 1 << bi;
          r = (sv >= 0) ? sv / p : -((-sv + p - 1) / p);
        end
      end
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, d, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic wait_state(input logic [4:0] st, input int max, input string tag);
    int i;
    i = 0;
    while (state_output !== st && i < max) begin
      @(negedge clk);
      i++;
    end
    check(tag, state_output, st);
  endtask

  task automatic write_reg(input logic [7:0] cmd, input logic [7:0] val);
    logic [4:0] st;
    st = (cmd == 8'h01) ? 5'b00010 : (cmd == 8'h02) ? 5'b00100 : 5'b01000;
    send_byte(cmd, 1'b1);
    check($sformatf("cmd%02h_state", cmd), state_output, st);
    send_byte(val, 1'b1);
    check($sformatf("cmd%02h_val%02h_idle", cmd, val), state_output, 5'b00001);
    case (cmd)
      8'h01:   a_m = val;
      8'h02:   b_m = val;
      default: op_m = val;
    endcase
    check($sformatf("data_out_a%02h_b%02h_op%02h", a_m, b_m, op_m), data_out,
          alu_ref(op_m, a_m, b_m));
  endtask

  task automatic do_send(input string tag);
    logic [7:0] exp;
    int i;
    exp = alu_ref(op_m, a_m, b_m);
    frames.delete();
    send_byte(8'h04, 1'b1);
    check({tag, "_send_state"}, state_output, 5'b10000);
    i = 0;
    while (frames.size() == 0 && i < 20 * BIT) begin
      @(negedge clk);
      i++;
    end
    if (frames.size() == 0) check({tag, "_tx_frame_seen"}, 0, 1);
    else check({tag, "_tx_frame"}, frames.pop_front(), {1'b1, exp, 1'b0});
    wait_state(5'b00001, 20 * BIT, {tag, "_back_idle"});
  endtask

  logic [7:0] sweep_op[8]  = '{8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02, 8'h3F};
  logic [7:0] sweep_exp[8] = '{8'hED, 8'h00, 8'hF3, 8'hF3, 8'h0C, 8'hFE, 8'h1E, 8'h00};
  logic [7:0] rand_ops[9]  = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02, 8'h3F};

  initial begin
    int tx_bad, tick_bad, n_ticks, last;
    logic [7:0] ra, rb;

    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_state", state_output, 5'b00001);
    check("reset_data_out", data_out, 8'h00);
    check("reset_tx", tx, 1'b1);

    tx_bad = 0; tick_bad = 0; n_ticks = 0; last = -1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_bad++;
      if (dut.u_baud.tick === 1'b1) begin
        if (last >= 0 && c - last != DIV) tick_bad++;
        last = c;
        n_ticks++;
      end
    end
    check("idle_tx_high", tx_bad, 0);
    check("tick_period", tick_bad, 0);
    check("tick_count", (n_ticks >= 2000 / DIV - 1), 1);

    write_reg(8'h01, 8'h07);
    write_reg(8'h02, 8'h02);
    write_reg(8'h03, 8'h20);
    check("add_7_2", data_out, 8'h09);
    do_send("send09");

    write_reg(8'h01, 8'hF0);
    write_reg(8'h02, 8'h03);
    for (int k = 0; k < 8; k++) begin
      write_reg(8'h03, sweep_op[k]);
      check($sformatf("sweep_op%02h", sweep_op[k]), data_out, sweep_exp[k]);
    end

    for (int k = 0; k < 4; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
      write_reg(8'h01, ra);
      write_reg(8'h02, rb);
      write_reg(8'h03, rand_ops[$urandom_range(0, 8)]);
    end
    do_send("send_rand");

    send_byte(8'h55, 1'b1);
    check("unknown_cmd_state", state_output, 5'b00001);
    check("unknown_cmd_data", data_out, alu_ref(op_m, a_m, b_m));

    send_byte(8'h01, 1'b1);
    check("glitch_pre_state", state_output, 5'b00010);
    @(negedge clk);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat (12 * BIT) @(negedge clk);
    check("glitch_state", state_output, 5'b00010);
    check("glitch_data", data_out, alu_ref(op_m, a_m, b_m));
    send_byte(8'h5A, 1'b1);
    a_m = 8'h5A;
    check("post_glitch_data", data_out, alu_ref(op_m, a_m, b_m));

    send_byte(8'h01, 1'b0);
    check("bad_stop_state", state_output, 5'b00001);
    repeat (15 * BIT) @(negedge clk);
    check("bad_stop_state_late", state_output, 5'b00001);
    check("bad_stop_data", data_out, alu_ref(op_m, a_m, b_m));

    send_byte(8'h04, 1'b1);
    check("midsend_state", state_output, 5'b10000);
    repeat (3 * BIT) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midsend_reset_tx", tx, 1'b1);
    check("midsend_reset_state", state_output, 5'b00001);
    check("midsend_reset_data", data_out, 8'h00);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    check("post_reset_tx", tx, 1'b1);
    check("post_reset_state", state_output, 5'b00001);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
